// File: rtl/serv_rf_sdp_if_if.sv
// Core/RAM-side signal bundle for the SERV register-file bridge.
// The bridge takes the slave view; whatever drives the core and RAM side takes the master view.
interface serv_rf_sdp_if_if #(
  parameter int W        = 1,
  parameter int RF_WIDTH = 2,
  parameter int AW       = 6,
  parameter int RF_L2D   = 10
);
  logic                i_rreq;
  logic                i_wreq;
  logic                o_ready;
  logic                o_busy;
  logic [AW-1:0]       i_rreg0;
  logic [AW-1:0]       i_rreg1;
  logic [W-1:0]        o_rdata0;
  logic [W-1:0]        o_rdata1;
  logic [AW-1:0]       i_wreg0;
  logic [AW-1:0]       i_wreg1;
  logic                i_wen0;
  logic                i_wen1;
  logic [W-1:0]        i_wdata0;
  logic [W-1:0]        i_wdata1;
  logic [RF_L2D-1:0]   o_waddr;
  logic [RF_WIDTH-1:0] o_wdata;
  logic                o_wen;
  logic [RF_L2D-1:0]   o_raddr;
  logic                o_ren;
  logic [RF_WIDTH-1:0] i_rdata;

  modport slave (
    input  i_rreq, i_wreq, i_rreg0, i_rreg1, i_wreg0, i_wreg1,
    input  i_wen0, i_wen1, i_wdata0, i_wdata1, i_rdata,
    output o_ready, o_busy, o_rdata0, o_rdata1,
    output o_waddr, o_wdata, o_wen, o_raddr, o_ren
  );

  modport master (
    output i_rreq, i_wreq, i_rreg0, i_rreg1, i_wreg0, i_wreg1,
    output i_wen0, i_wen1, i_wdata0, i_wdata1, i_rdata,
    input  o_ready, o_busy, o_rdata0, o_rdata1,
    input  o_waddr, o_wdata, o_wen, o_raddr, o_ren
  );
endinterface

// File: rtl/serv_rf_sdp_if.sv
// Bridges SERV's two W-bit serial read and write streams onto a simple-dual-port RAM
// of RF_WIDTH-bit words; all timing is derived from one cycle counter per transaction.
module serv_rf_sdp_if #(
  parameter int W              = 1,
  parameter int RF_WIDTH       = 2,
  parameter int CSR_REGS       = 4,
  parameter int RAM_LAT        = 1,
  parameter     RESET_STRATEGY = "MINI"
) (
  input logic              i_clk,
  input logic              i_rst,
  serv_rf_sdp_if_if.slave  bus
);
  localparam int AW     = 5 + ((CSR_REGS > 0) ? 1 : 0);
  localparam int WPR    = 32 / RF_WIDTH;
  localparam int RATIO  = RF_WIDTH / W;
  localparam int TRANS  = 32 / W;
  localparam int RF_L2D = $clog2((32 + CSR_REGS) * WPR);
  localparam int L2R    = $clog2(RATIO);
  localparam int L2WPR  = $clog2(WPR);
  localparam int CW     = $clog2(TRANS + RAM_LAT + 4) + 1;
  localparam bit RST_EN = (RESET_STRATEGY != "NONE");

  localparam logic [CW-1:0] C_ONE    = CW'(1);
  localparam logic [CW-1:0] C_TWO    = CW'(2);
  localparam logic [CW-1:0] C_THREE  = CW'(3);
  localparam logic [CW-1:0] C_TRANS  = CW'(TRANS);
  localparam logic [CW-1:0] C_RATIO  = CW'(RATIO);
  localparam logic [CW-1:0] M_CHUNK  = CW'(RATIO - 1);
  localparam logic [CW-1:0] M_RDSLOT = CW'(RATIO - 2);
  localparam logic [CW-1:0] RD_READY = CW'(RAM_LAT + 1);
  localparam logic [CW-1:0] RD_LAST  = CW'(RAM_LAT + 1 + TRANS);
  localparam logic [CW-1:0] WR_LAST  = CW'(TRANS + 3);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [RF_WIDTH-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
  logic [RF_WIDTH-1:0] wb0_q, wb0_d, wb1_q, wb1_d, wh1_q, wh1_d;
  logic                ready, ren, wen;
  logic [RF_L2D-1:0]   raddr, waddr;
  logic [RF_WIDTH-1:0] wdata;
  logic [W-1:0]        rdata0, rdata1;
  logic [CW-1:0]       t_rd, t_cap, t_out, t_w0, t_w1;

  function automatic logic [RF_L2D-1:0] ram_addr(input logic [AW-1:0] r, input logic [CW-1:0] k);
    return (RF_L2D'(r) << L2WPR) | RF_L2D'(k);
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + C_ONE;
    ready   = 1'b0;
    ren     = 1'b0;
    wen     = 1'b0;
    raddr   = '0;
    waddr   = '0;
    wdata   = wb0_q;
    t_rd    = cnt_q - C_ONE;
    t_cap   = cnt_q - RD_READY;
    t_out   = t_cap - C_ONE;
    t_w0    = cnt_q - C_TWO;
    t_w1    = cnt_q - C_THREE;
    rd0_d   = rd0_q >> W;
    rd1_d   = rd1_q >> W;
    rdata0  = rd0_q[W-1:0];
    rdata1  = rd1_q[W-1:0];
    wb0_d   = {bus.i_wdata0, wb0_q[RF_WIDTH-1:W]};
    wb1_d   = {bus.i_wdata1, wb1_q[RF_WIDTH-1:W]};
    wh1_d   = wh1_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = C_ONE;
        if (bus.i_rreq)      state_d = S_READ;
        else if (bus.i_wreq) state_d = S_WRITE;
      end
      S_READ: begin
        ready = (cnt_q == RD_READY);
        // First two slots of every RATIO-cycle window fetch rreg0 then rreg1 word k.
        if (t_rd < C_TRANS && (t_rd & M_RDSLOT) == '0) begin
          ren   = 1'b1;
          raddr = ram_addr(t_rd[0] ? bus.i_rreg1 : bus.i_rreg0, t_rd >> L2R);
        end
        if (t_cap < C_TRANS && (t_cap & M_CHUNK) == '0)
          rd0_d = bus.i_rdata;
        // The rreg1 word arrives exactly when its first chunk is due, so pass it straight through.
        if ((t_out & M_CHUNK) == '0) begin
          rdata1 = bus.i_rdata[W-1:0];
          rd1_d  = bus.i_rdata >> W;
        end
        if (cnt_q == RD_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_WRITE: begin
        ready = (cnt_q == C_ONE);
        if (t_w0 >= C_RATIO && t_w0 <= C_TRANS && (t_w0 & M_CHUNK) == '0) begin
          wen   = bus.i_wen0 && (bus.i_wreg0 != '0);
          waddr = ram_addr(bus.i_wreg0, (t_w0 >> L2R) - C_ONE);
          wdata = wb0_q;
          wh1_d = wb1_q;
        end
        if (t_w1 >= C_RATIO && t_w1 <= C_TRANS && (t_w1 & M_CHUNK) == '0) begin
          wen   = bus.i_wen1 && (bus.i_wreg1 != '0);
          waddr = ram_addr(bus.i_wreg1, (t_w1 >> L2R) - C_ONE);
          wdata = wh1_q;
        end
        if (cnt_q == WR_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    rd0_q   <= rd0_d;
    rd1_q   <= rd1_d;
    wb0_q   <= wb0_d;
    wb1_q   <= wb1_d;
    wh1_q   <= wh1_d;
    if (RST_EN && i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end
  end

  assign bus.o_ready  = ready;
  assign bus.o_busy   = (state_q != S_IDLE);
  assign bus.o_ren    = ren;
  assign bus.o_raddr  = raddr;
  assign bus.o_wen    = wen;
  assign bus.o_waddr  = waddr;
  assign bus.o_wdata  = wdata;
  assign bus.o_rdata0 = rdata0;
  assign bus.o_rdata1 = rdata1;
endmodule

// File: tb/tb_serv_rf_sdp_if.sv
// Bench for serv_rf_sdp_if: two configurations (A: W=1/RF=2/LAT=1, B: W=2/RF=8/LAT=2)
// driven from a transaction table plus random transactions against a register-level model.
module tb_serv_rf_sdp_if;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, ram_clr, sel;
  logic       rreq, wreq, we0, we1;
  logic [5:0] rr0, rr1, wr0, wr1;
  logic [1:0] wd0, wd1;

  serv_rf_sdp_if_if #(.W(1), .RF_WIDTH(2), .AW(6), .RF_L2D(10)) bus_a();
  serv_rf_sdp_if_if #(.W(2), .RF_WIDTH(8), .AW(6), .RF_L2D(8))  bus_b();

  serv_rf_sdp_if #(.W(1), .RF_WIDTH(2), .CSR_REGS(4), .RAM_LAT(1), .RESET_STRATEGY("MINI"))
    dut_a (.i_clk(clk), .i_rst(rst), .bus(bus_a.slave));
  serv_rf_sdp_if #(.W(2), .RF_WIDTH(8), .CSR_REGS(4), .RAM_LAT(2), .RESET_STRATEGY("MINI"))
    dut_b (.i_clk(clk), .i_rst(rst), .bus(bus_b.slave));

  assign bus_a.i_rreq = rreq & ~sel;   assign bus_b.i_rreq = rreq & sel;
  assign bus_a.i_wreq = wreq & ~sel;   assign bus_b.i_wreq = wreq & sel;
  assign bus_a.i_rreg0 = rr0;  assign bus_a.i_rreg1 = rr1;
  assign bus_b.i_rreg0 = rr0;  assign bus_b.i_rreg1 = rr1;
  assign bus_a.i_wreg0 = wr0;  assign bus_a.i_wreg1 = wr1;
  assign bus_b.i_wreg0 = wr0;  assign bus_b.i_wreg1 = wr1;
  assign bus_a.i_wen0 = we0;   assign bus_a.i_wen1 = we1;
  assign bus_b.i_wen0 = we0;   assign bus_b.i_wen1 = we1;
  assign bus_a.i_wdata0 = wd0[0];  assign bus_a.i_wdata1 = wd1[0];
  assign bus_b.i_wdata0 = wd0;     assign bus_b.i_wdata1 = wd1;

  // RAM models: A has 1-cycle read latency, B has 2
  logic [1:0] mem_a [1024];
  logic [7:0] mem_b [256];
  logic [1:0] pa1;
  logic [7:0] pb1, pb2;
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 1024; i++) mem_a[i] <= '0;
    end else begin
      if (bus_a.o_wen) mem_a[bus_a.o_waddr] <= bus_a.o_wdata;
      if (bus_a.o_ren) pa1 <= mem_a[bus_a.o_raddr];
    end
  end
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) mem_b[i] <= '0;
    end else begin
      if (bus_b.o_wen) mem_b[bus_b.o_waddr] <= bus_b.o_wdata;
      if (bus_b.o_ren) pb1 <= mem_b[bus_b.o_raddr];
      pb2 <= pb1;
    end
  end
  assign bus_a.i_rdata = pa1;
  assign bus_b.i_rdata = pb2;

  logic       m_ready, m_busy, m_ren, m_wen;
  logic [9:0] m_raddr, m_waddr;
  logic [7:0] m_wdata;
  logic [1:0] m_rd0, m_rd1;
  always_comb begin
    if (sel) begin
      m_ready = bus_b.o_ready;  m_busy = bus_b.o_busy;
      m_ren = bus_b.o_ren;      m_wen = bus_b.o_wen;
      m_raddr = {2'b0, bus_b.o_raddr};  m_waddr = {2'b0, bus_b.o_waddr};
      m_wdata = bus_b.o_wdata;
      m_rd0 = bus_b.o_rdata0;   m_rd1 = bus_b.o_rdata1;
    end else begin
      m_ready = bus_a.o_ready;  m_busy = bus_a.o_busy;
      m_ren = bus_a.o_ren;      m_wen = bus_a.o_wen;
      m_raddr = bus_a.o_raddr;  m_waddr = bus_a.o_waddr;
      m_wdata = {6'b0, bus_a.o_wdata};
      m_rd0 = {1'b0, bus_a.o_rdata0};  m_rd1 = {1'b0, bus_a.o_rdata1};
    end
  end

  // Register-level reference: 36 registers of 32 bits per configuration
  logic [31:0] gold_a [36];
  logic [31:0] gold_b [36];
  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        sel;
    logic        wr;
    logic [5:0]  r0, r1;
    logic        we0, we1;
    logic [31:0] d0, d1;
    int          abort_cyc;
    int          dup_cyc;
    int          exp_ready;
    int          exp_nacc;
  } txn_t;

  txn_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
  endtask

  function automatic logic [31:0] gold_get(input logic s, input int r);
    return s ? gold_b[r] : gold_a[r];
  endfunction

  task automatic gold_put(input logic s, input int r, input logic [31:0] v);
    if (s) gold_b[r] = v;
    else   gold_a[r] = v;
  endtask

  function automatic txn_t mk_rand();
    txn_t t;
    int wpr;
    t.sel = 1'($urandom_range(0, 1));
    t.wr  = 1'($urandom_range(0, 1));
    t.r0  = 6'($urandom_range(0, 35));
    t.r1  = 6'($urandom_range(0, 35));
    t.we0 = 1'($urandom_range(0, 1));
    t.we1 = 1'($urandom_range(0, 1));
    t.d0  = $urandom;
    t.d1  = $urandom;
    t.abort_cyc = 1000;
    t.dup_cyc   = -1;
    wpr = t.sel ? 4 : 16;
    t.exp_ready = t.wr ? 1 : (t.sel ? 3 : 2);
    if (t.wr)
      t.exp_nacc = wpr * (((t.we0 && t.r0 != 0) ? 1 : 0) + ((t.we1 && t.r1 != 0) ? 1 : 0));
    else
      t.exp_nacc = 2 * wpr;
    return t;
  endfunction

  task automatic run_txn(input int idx, input txn_t t);
    int w_, rf, lat, r, wpr, trans, endc, c;
    int nready, ready_at, nacc, sched_bad, busy_bad, first_bad;
    logic        exp_acc [64];
    int          exp_addr [64];
    logic [7:0]  exp_wd [64];
    logic [31:0] mk, cm, got0, got1, g;
    logic        acc, other, exp_busy;
    int          addr;
    w_ = t.sel ? 2 : 1;  rf = t.sel ? 8 : 2;  lat = t.sel ? 2 : 1;
    r = rf / w_;  wpr = 32 / rf;  trans = 32 / w_;
    endc = t.wr ? trans + 3 : lat + 1 + trans;
    mk = (32'h1 << rf) - 32'h1;
    cm = (32'h1 << w_) - 32'h1;
    for (int n = 0; n < 64; n++) begin exp_acc[n] = 1'b0; exp_addr[n] = 0; exp_wd[n] = '0; end
    for (int k = 0; k < wpr; k++) begin
      if (!t.wr) begin
        exp_acc[1 + k*r] = 1'b1;  exp_addr[1 + k*r] = int'(t.r0) * wpr + k;
        exp_acc[2 + k*r] = 1'b1;  exp_addr[2 + k*r] = int'(t.r1) * wpr + k;
      end else begin
        if (t.we0 && t.r0 != 0) begin
          exp_acc[2 + (k+1)*r] = 1'b1;  exp_addr[2 + (k+1)*r] = int'(t.r0) * wpr + k;
          exp_wd[2 + (k+1)*r]  = 8'((t.d0 >> (k*rf)) & mk);
        end
        if (t.we1 && t.r1 != 0) begin
          exp_acc[3 + (k+1)*r] = 1'b1;  exp_addr[3 + (k+1)*r] = int'(t.r1) * wpr + k;
          exp_wd[3 + (k+1)*r]  = 8'((t.d1 >> (k*rf)) & mk);
        end
      end
    end
    for (int n = 0; n < 64; n++) if (n > t.abort_cyc) exp_acc[n] = 1'b0;

    nready = 0; ready_at = -1; nacc = 0; sched_bad = 0; busy_bad = 0; first_bad = -1;
    got0 = '0; got1 = '0;
    for (int n = 0; n <= endc + 1; n++) begin
      @(negedge clk);
      sel = t.sel;
      rr0 = t.r0; rr1 = t.r1; wr0 = t.r0; wr1 = t.r1; we0 = t.we0; we1 = t.we1;
      rreq = (!t.wr && n == 0) || (n == t.dup_cyc);
      wreq = t.wr && n == 0;
      rst  = (n == t.abort_cyc);
      if (n >= 2 && n - 2 < trans) begin
        wd0 = 2'((t.d0 >> ((n-2)*w_)) & cm);
        wd1 = 2'((t.d1 >> ((n-2)*w_)) & cm);
      end else begin
        wd0 = 2'($urandom);
        wd1 = 2'($urandom);
      end
      #1;
      if (m_ready) begin nready++; ready_at = n; end
      acc   = t.wr ? m_wen : m_ren;
      other = t.wr ? m_ren : m_wen;
      addr  = t.wr ? int'(m_waddr) : int'(m_raddr);
      if (acc) nacc++;
      if (acc !== exp_acc[n] || other !== 1'b0 ||
          (acc && (addr != exp_addr[n] || (t.wr && m_wdata != exp_wd[n])))) begin
        sched_bad++;
        if (first_bad < 0) first_bad = n;
      end
      exp_busy = (n >= 1 && n <= endc && n <= t.abort_cyc);
      if (m_busy !== exp_busy) busy_bad++;
      if (!t.wr && n >= lat + 2 && n < lat + 2 + trans) begin
        c = n - lat - 2;
        got0 = got0 | (({30'b0, m_rd0} & cm) << (c*w_));
        got1 = got1 | (({30'b0, m_rd1} & cm) << (c*w_));
      end
    end
    rreq = 1'b0; wreq = 1'b0; rst = 1'b0;

    chk("ready_cycle", (nready == 1) ? ready_at : -1, t.exp_ready);
    chk("ram_access_count", nacc, t.exp_nacc);
    chk("ram_access_schedule_first_bad_cycle", first_bad, -1);
    chk("busy_bad_cycles", busy_bad, 0);
    if (!t.wr) begin
      chk("rdata0_stream", got0, gold_get(t.sel, int'(t.r0)));
      chk("rdata1_stream", got1, gold_get(t.sel, int'(t.r1)));
    end else begin
      for (int k = 0; k < wpr; k++) begin
        if (t.we0 && t.r0 != 0 && 2 + (k+1)*r <= t.abort_cyc) begin
          g = gold_get(t.sel, int'(t.r0));
          g = (g & ~(mk << (k*rf))) | (((t.d0 >> (k*rf)) & mk) << (k*rf));
          gold_put(t.sel, int'(t.r0), g);
        end
        if (t.we1 && t.r1 != 0 && 3 + (k+1)*r <= t.abort_cyc) begin
          g = gold_get(t.sel, int'(t.r1));
          g = (g & ~(mk << (k*rf))) | (((t.d1 >> (k*rf)) & mk) << (k*rf));
          gold_put(t.sel, int'(t.r1), g);
        end
      end
    end
    $display("txn %0d cfg=%s %s r0=%0d r1=%0d ready@%0d accesses=%0d got0=%h got1=%h",
             idx, t.sel ? "B" : "A", t.wr ? "write" : "read", t.r0, t.r1,
             ready_at, nacc, got0, got1);
  endtask

  initial begin
    logic [31:0] beef;
    int bad;
    rst = 1'b1; ram_clr = 1'b1; sel = 1'b0;
    rreq = 1'b0; wreq = 1'b0; we0 = 1'b0; we1 = 1'b0;
    rr0 = '0; rr1 = '0; wr0 = '0; wr1 = '0; wd0 = '0; wd1 = '0;
    for (int i = 0; i < 36; i++) begin gold_a[i] = '0; gold_b[i] = '0; end

    //           sel   wr    r0     r1     we0   we1   d0            d1            abort dup ready nacc
    tbl[0] = '{1'b0, 1'b1, 6'd5,  6'd6,  1'b1, 1'b1, 32'hDEADBEEF, 32'h12345678, 1000, -1, 1, 32};
    tbl[1] = '{1'b0, 1'b0, 6'd5,  6'd6,  1'b0, 1'b0, 32'h0,        32'h0,        1000, -1, 2, 32};
    tbl[2] = '{1'b0, 1'b1, 6'd0,  6'd7,  1'b1, 1'b1, 32'hFFFFFFFF, 32'hA5A50F0F, 1000, -1, 1, 16};
    tbl[3] = '{1'b0, 1'b0, 6'd0,  6'd7,  1'b0, 1'b0, 32'h0,        32'h0,        1000, -1, 2, 32};
    tbl[4] = '{1'b1, 1'b1, 6'd9,  6'd10, 1'b1, 1'b1, 32'hCAFEF00D, 32'h0BADC0DE, 1000, -1, 1, 8};
    tbl[5] = '{1'b1, 1'b0, 6'd9,  6'd10, 1'b0, 1'b0, 32'h0,        32'h0,        1000, -1, 3, 8};
    tbl[6] = '{1'b0, 1'b1, 6'd20, 6'd21, 1'b1, 1'b1, 32'h13579BDF, 32'h2468ACE0, 10,   -1, 1, 7};
    tbl[7] = '{1'b0, 1'b0, 6'd20, 6'd21, 1'b0, 1'b0, 32'h0,        32'h0,        1000,  5, 2, 32};

    repeat (3) @(negedge clk);
    rst = 1'b0; ram_clr = 1'b0;
    #1;
    chk("reset_a_ready", bus_a.o_ready, 0);
    chk("reset_a_busy",  bus_a.o_busy,  0);
    chk("reset_a_wen",   bus_a.o_wen,   0);
    chk("reset_a_ren",   bus_a.o_ren,   0);
    chk("reset_b_ready", bus_b.o_ready, 0);
    chk("reset_b_busy",  bus_b.o_busy,  0);
    chk("reset_b_wen",   bus_b.o_wen,   0);
    chk("reset_b_ren",   bus_b.o_ren,   0);

    for (int i = 0; i < 8; i++) run_txn(i, tbl[i]);

    beef = 32'hDEADBEEF;
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      if (mem_a[5*16 + k] !== beef[2*k +: 2]) bad++;
      if (mem_a[k] !== 2'b00) bad++;
    end
    chk("ram_x5_and_x0_contents_bad_words", bad, 0);

    for (int i = 0; i < 24; i++) run_txn(8 + i, mk_rand());

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/serv_rf_sdp_if.md
Name: serv_rf_sdp_if

Overview:
- Parametrised bridge between SERV's bit-serial register-file ports and a simple-dual-port RAM: 2 read streams, 2 write streams, W bits per cycle each.
- Generalises the fixed RF_WIDTH=2W interface to any power-of-two RAM width ratio.
- Adds a configurable RAM read latency and an explicit busy indication.
- Sits between the core and the RF RAM inside the RF top-level wrapper.

Parameters:
- W, 1, core serial lane width (1, 2, 4, 8...; divides 32).
- RF_WIDTH, 2, RAM word width; RATIO = RF_WIDTH/W, power of two, RATIO >= 2, RF_WIDTH <= 32.
- CSR_REGS, 4, extra registers after the 32 GPRs (0 or 4).
- RAM_LAT, 1, RAM read latency in cycles (1 or 2).
- RESET_STRATEGY, "MINI", "MINI" resets control state; "NONE" resets nothing.
- Derived:
  - AW = 5 + (CSR_REGS>0).
  - WPR = 32/RF_WIDTH (words per register).
  - TRANS = 32/W.
  - RF_L2D = clog2((32+CSR_REGS)*WPR).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_rreq  in  1  read transaction request (1-cycle pulse).
- i_wreq  in  1  write transaction request (1-cycle pulse).
- o_ready  out  1  1-cycle start strobe; data streams begin the next cycle.
- o_busy  out  1  transaction in progress.
- i_rreg0, i_rreg1  in  AW  read register numbers; held stable for the whole transaction.
- o_rdata0, o_rdata1  out  W  read streams, LSB chunk first.
- i_wreg0, i_wreg1  in  AW  write register numbers; held stable.
- i_wen0, i_wen1  in  1  write enables; held stable.
- i_wdata0, i_wdata1  in  W  write streams, LSB chunk first.
- o_waddr  out  RF_L2D  RAM write address.
- o_wdata  out  RF_WIDTH  RAM write data.
- o_wen  out  1  RAM write enable.
- o_raddr  out  RF_L2D  RAM read address.
- o_ren  out  1  RAM read enable.
- i_rdata  in  RF_WIDTH  RAM read data, valid RAM_LAT cycles after o_ren.

Behaviour:
- Reset ("MINI"): o_ready=0, o_busy=0, o_wen=0, o_ren=0, counters cleared, pending write buffers dropped. Other outputs are don't-care.
- Address mapping: RAM addr = {reg, word index k}, k in 0..WPR-1. Chunk j of a word occupies bits [j*W +: W]. Register bit b is in word b/RF_WIDTH.
- Requests:
  - A request is accepted only when o_busy=0. i_rreq and i_wreq are never asserted in the same cycle.
  - A request asserted while busy is ignored: no strobe, no RAM activity.
  - o_busy rises the cycle after acceptance and falls after the last RAM access of the transaction.
- Read transaction (cycles counted from request cycle 0):
  - RAM reads issued at cycle 1+k*RATIO for rreg0 word k and at 2+k*RATIO for rreg1 word k.
  - o_ren is high only in those cycles: exactly 2*WPR reads.
  - o_ready pulses at cycle RAM_LAT+1.
  - o_rdata0/o_rdata1 present chunk c of each register in cycle RAM_LAT+2+c, for c = 0..TRANS-1.
  - The rreg0 word is buffered until its rreg1 partner arrives.
  - o_busy falls after the cycle with the last chunk.
- Write transaction:
  - o_ready pulses at cycle 1; chunk c is sampled in cycle 2+c.
  - The port-0 word k is written at cycle 2+(k+1)*RATIO.
  - The port-1 word k is buffered and written at cycle 3+(k+1)*RATIO.
  - At most one RAM write per cycle. o_busy falls after the cycle TRANS+3 write slot.
  - A word is written only if that port's wen is 1 and its wreg != 0. x0 is never written.
- Read-during-write to the same RAM address: no forwarding. The core guarantees no such hazard.
- Reset mid-transaction: the transaction aborts. No o_wen/o_ren from the cycle after i_rst is sampled. o_ready is not emitted.
- RAM_LAT=2 shifts only the read data path. Write timing is unchanged.

Test Plan:
- Reset (W=1, RF_WIDTH=2, RAM_LAT=1) -> o_ready=o_busy=o_wen=o_ren=0 the cycle after reset.
- Write burst: i_wreq with wreg0=5, wdata 0xDEADBEEF (wen0=1), and wreg1=6, wdata 0x12345678 (wen1=1) -> o_ready at cycle 1. Exactly 32 o_wen pulses: port 0 at even cycles 4..34, port 1 at odd cycles 5..35. RAM[{5,k}] = bits [2k+1:2k] of 0xDEADBEEF.
- Read-back: i_rreq with rreg0=5, rreg1=6 -> o_ready at cycle 2. o_rdata0 streams 0xDEADBEEF and o_rdata1 streams 0x12345678 LSB first over cycles 3..34. 32 o_ren pulses.
- Write to x0 with wen0=1 and data 0xFFFFFFFF -> no o_wen for reg-0 addresses. Read of x0 returns 0.
- W=2, RF_WIDTH=8, RAM_LAT=2 write then read -> read o_ready at cycle 3. 16 chunk cycles 4..19. 8 reads. Values round-trip exactly.
- Abort/ignore:
  - Assert i_rst at cycle 10 of a write -> no o_wen from cycle 11; o_busy=0.
  - A second i_rreq during a busy read -> ignored; the single o_ready is unchanged.
